sargantana_icache_refill: RTL and testbench
===========================================

# sargantana_icache_refill

Line-refill controller for the Sargantana instruction cache. It sits directly upstream of the per-way data memory. On a miss it:
- issues one line request to L2;
- assembles the returned beats into a full set-width line;
- picks a victim way;
- drives a single one-hot write into the data memory.

The tag/valid stage uses `done_o` and `done_way_o` to update its own arrays.

## Interface
Parameters:
- `ICACHE_N_WAY`, 4, number of ways (power of two, ≥2)
- `SET_WIDHT`, 256, line width in bits, equal to the data-memory word
- `ADDR_WIDHT`, 6, set-index width
- `BEAT_WIDTH`, 64, L2 response beat width; `SET_WIDHT` must be a multiple of it

Ports:
- `clk_i` in 1, clock
- `rstn_i` in 1, asynchronous active-low reset
- `miss_valid_i` in 1, miss request valid
- `miss_ready_o` out 1, controller idle and able to accept a miss
- `miss_idx_i` in `ADDR_WIDHT`, set index of the missing line
- `way_valid_i` in `ICACHE_N_WAY`, valid bits of the indexed set, sampled with the miss
- `kill_i` in 1, flush/abort of the outstanding refill
- `l2_req_valid_o` out 1, line request to L2
- `l2_req_ready_i` in 1, L2 accepts the request
- `l2_req_idx_o` out `ADDR_WIDHT`, set index of the request
- `l2_rsp_valid_i` in 1, response beat valid; there is no backpressure and beats arrive in order, beat 0 first
- `l2_rsp_data_i` in `BEAT_WIDTH`, beat payload
- `mem_req_o` out `ICACHE_N_WAY`, one-hot way enable to the data memory
- `mem_we_o` out 1, write enable
- `mem_addr_o` out `ADDR_WIDHT`, set index
- `mem_data_o` out `SET_WIDHT`, assembled line
- `done_o` out 1, one-cycle pulse when a line has been written
- `done_way_o` out `ICACHE_N_WAY`, one-hot victim way, valid while `done_o` is high

## Operation
- `NBEATS = SET_WIDHT/BEAT_WIDTH`. The beat counter is `$clog2(NBEATS)` bits wide, with a minimum of 1 bit.
- FSM states: IDLE, REQ, FILL, WRITE.
- **IDLE**
  - `miss_ready_o=1`.
  - On `miss_valid_i`: capture `miss_idx_i`, compute and register the victim, clear the beat counter and the kill flag, go to REQ.
- **Victim selection**
  - If any bit of `way_valid_i` is 0, the victim is the lowest-index invalid way.
  - Otherwise the victim is the round-robin pointer.
  - The pointer advances by 1 modulo `ICACHE_N_WAY` only when it supplied a victim whose write completes in WRITE.
- **REQ**
  - `l2_req_valid_o=1` and `l2_req_idx_o` is the captured index; both are held until `l2_req_ready_i`.
  - On handshake, go to FILL.
  - `kill_i` before the handshake: drop `l2_req_valid_o` and go to IDLE. If the handshake and `kill_i` occur in the same cycle, the handshake wins: go to FILL with the kill flag set.
- **FILL**
  - Each `l2_rsp_valid_i` beat `k` is written to `line[k*BEAT_WIDTH +: BEAT_WIDTH]` and the counter increments.
  - On beat `NBEATS-1`: go to WRITE, or to IDLE if the kill flag is set.
  - `kill_i` during FILL sets the kill flag. The remaining beats are still drained and nothing is written.
- **WRITE** (one cycle)
  - `mem_req_o` = victim one-hot, `mem_we_o=1`, `done_o=1`, `done_way_o` = victim. Then go to IDLE.
  - `kill_i` in WRITE is ignored.
- Outside WRITE, `mem_req_o=0`, `mem_we_o=0`, `done_o=0`.
- `mem_addr_o` and `mem_data_o` are registered and always reflect the captured index and the line buffer.

## Timing
- Reset (asynchronous, `rstn_i=0`):
  - state IDLE, all outputs 0 except `miss_ready_o=1`;
  - line buffer, index, counter, kill flag and RR pointer cleared to 0.
- Reset mid-refill aborts it immediately with no memory write. A late L2 beat arriving after reset is ignored in IDLE.
- Miss accepted at cycle 0 → `l2_req_valid_o` high at cycle 1.
- L2 handshake at cycle t → FILL from t+1. Beats are accepted in the same cycle they are valid.
- Last beat at cycle u → write at u+1 → `miss_ready_o` at u+2.
- Minimum miss-to-write latency is `NBEATS+2` cycles.
- A new miss is never accepted in the same cycle as `done_o`.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs except none.

## Structure
- `sargantana_icache_pkg` holds:
  - the `refill_state_t` enum {IDLE, REQ, FILL, WRITE};
  - an `icache_refill_nbeats` function for `SET_WIDHT/BEAT_WIDTH`.
- Sub-module `sargantana_icache_victim_sel` contains the lowest-invalid priority encoder plus the RR pointer register with an advance strobe. Its outputs are a one-hot victim and a `from_rr` flag.
- This block's memory outputs connect port-for-port to the data-memory `req_i`/`we_i`/`addr_i`/`data_i`.

## Test plan
- Miss idx=0x15, `way_valid_i`=4'b1011, beats 0x1111…,0x2222…,0x3333…,0x4444… → one write: `mem_req_o`=4'b0100, `mem_addr_o`=0x15, `mem_data_o`={beat3,beat2,beat1,beat0}, `done_o` pulse.
- Four consecutive misses, all ways valid → victims 0001,0010,0100,1000, then 0001 again. An interleaved miss with an invalid way does not advance the pointer.
- `l2_req_ready_i` held low 5 cycles → `l2_req_valid_o` and `l2_req_idx_o` stable for 5 cycles; FILL starts the cycle after ready.
- `kill_i` after beat 1 → remaining beats drained, no `mem_we_o`, no `done_o`, `miss_ready_o`=1 the cycle after the last beat. `kill_i` in REQ → IDLE next cycle with no L2 handshake.
- Beats with gaps (valid 1,0,0,1,1,0,1) → correct assembly, write one cycle after the 4th valid beat.
- `rstn_i` asserted in FILL → outputs reset asynchronously; a subsequent miss refills cleanly and the RR pointer restarts at way 0.

Source files
------------

// File: rtl/sargantana_icache_refill_pkg.sv
// Shared types and helpers for the Sargantana instruction-cache refill path.
package sargantana_icache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FILL  = 2'd2,
      WRITE = 2'd3
   } refill_state_t;

   // Number of L2 beats that make up one full cache line.
   function automatic int icache_refill_nbeats(input int set_widht, input int beat_width);
      return set_widht / beat_width;
   endfunction

endpackage

// File: rtl/sargantana_icache_refill_if.sv
// Bundle of miss, L2 and data-memory signals around the refill controller.
interface sargantana_icache_refill_if #(
   parameter int ICACHE_N_WAY = 4,
   parameter int SET_WIDHT    = 256,
   parameter int ADDR_WIDHT   = 6,
   parameter int BEAT_WIDTH   = 64
);
   logic                    miss_valid_i;
   logic                    miss_ready_o;
   logic [ADDR_WIDHT-1:0]   miss_idx_i;
   logic [ICACHE_N_WAY-1:0] way_valid_i;
   logic                    kill_i;
   logic                    l2_req_valid_o;
   logic                    l2_req_ready_i;
   logic [ADDR_WIDHT-1:0]   l2_req_idx_o;
   logic                    l2_rsp_valid_i;
   logic [BEAT_WIDTH-1:0]   l2_rsp_data_i;
   logic [ICACHE_N_WAY-1:0] mem_req_o;
   logic                    mem_we_o;
   logic [ADDR_WIDHT-1:0]   mem_addr_o;
   logic [SET_WIDHT-1:0]    mem_data_o;
   logic                    done_o;
   logic [ICACHE_N_WAY-1:0] done_way_o;

   // Refill controller side.
   modport master (
      input  miss_valid_i, miss_idx_i, way_valid_i, kill_i,
      input  l2_req_ready_i, l2_rsp_valid_i, l2_rsp_data_i,
      output miss_ready_o, l2_req_valid_o, l2_req_idx_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_data_o, done_o, done_way_o
   );

   // Surrounding cache / L2 / memory side.
   modport slave (
      output miss_valid_i, miss_idx_i, way_valid_i, kill_i,
      output l2_req_ready_i, l2_rsp_valid_i, l2_rsp_data_i,
      input  miss_ready_o, l2_req_valid_o, l2_req_idx_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o, done_o, done_way_o
   );
endinterface

// File: rtl/sargantana_icache_refill_victim_sel.sv
// Victim way selection: lowest invalid way first, otherwise a round-robin pointer.
module sargantana_icache_victim_sel #(
   parameter int ICACHE_N_WAY = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [ICACHE_N_WAY-1:0] way_valid,
   input  logic                    advance,
   output logic [ICACHE_N_WAY-1:0] victim,
   output logic                    from_rr
);
   localparam int PTR_W = $clog2(ICACHE_N_WAY);

   logic [PTR_W-1:0] rr_ptr;

   // Scan from the top so the lowest invalid way is the one that sticks.
   always_comb begin
      victim  = '0;
      from_rr = 1'b1;
      for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
         if (!way_valid[w]) begin
            victim    = '0;
            victim[w] = 1'b1;
            from_rr   = 1'b0;
         end
      end
      if (from_rr) begin
         victim[rr_ptr] = 1'b1;
      end
   end

   // Pointer moves only when a round-robin victim actually got written.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= rr_ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/sargantana_icache_refill.sv
// Line-refill controller: one L2 request per miss, beat assembly, one-hot line write.
module sargantana_icache_refill
   import sargantana_icache_pkg::*;
#(
   parameter int ICACHE_N_WAY = 4,
   parameter int SET_WIDHT    = 256,
   parameter int ADDR_WIDHT   = 6,
   parameter int BEAT_WIDTH   = 64
) (
   input logic                        clk_i,
   input logic                        rstn_i,
   sargantana_icache_refill_if.master bus
);
   localparam int NBEATS = icache_refill_nbeats(SET_WIDHT, BEAT_WIDTH);
   localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   refill_state_t           state_q, state_d;
   logic [ADDR_WIDHT-1:0]   idx_q;
   logic [SET_WIDHT-1:0]    line_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    kill_q;
   logic [ICACHE_N_WAY-1:0] victim_q;
   logic                    from_rr_q;
   logic [ICACHE_N_WAY-1:0] victim_sel;
   logic                    from_rr_sel;
   logic                    last_beat;
   logic                    advance;
   logic                    miss_ready;
   logic                    l2_req_valid;
   logic                    writing;

   assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));
   assign advance   = (state_q == WRITE) && from_rr_q;

   sargantana_icache_victim_sel #(
      .ICACHE_N_WAY(ICACHE_N_WAY)
   ) victim_sel_inst (
      .clk      (clk_i),
      .rstn     (rstn_i),
      .way_valid(bus.way_valid_i),
      .advance  (advance),
      .victim   (victim_sel),
      .from_rr  (from_rr_sel)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and state-decoded outputs; a handshake beats a same-cycle kill in REQ.
   always_comb begin
      state_d      = state_q;
      miss_ready   = 1'b0;
      l2_req_valid = 1'b0;
      writing      = 1'b0;
      case (state_q)
         IDLE: begin
            miss_ready = 1'b1;
            if (bus.miss_valid_i) state_d = REQ;
         end
         REQ: begin
            l2_req_valid = 1'b1;
            if (bus.l2_req_ready_i) state_d = FILL;
            else if (bus.kill_i)    state_d = IDLE;
         end
         FILL: begin
            if (bus.l2_rsp_valid_i && last_beat) begin
               state_d = (kill_q || bus.kill_i) ? IDLE : WRITE;
            end
         end
         WRITE: begin
            writing = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the miss, assemble beats into the line buffer, and remember a late kill.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         idx_q     <= '0;
         line_q    <= '0;
         cnt_q     <= '0;
         kill_q    <= 1'b0;
         victim_q  <= '0;
         from_rr_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.miss_valid_i) begin
                  idx_q     <= bus.miss_idx_i;
                  victim_q  <= victim_sel;
                  from_rr_q <= from_rr_sel;
                  cnt_q     <= '0;
                  kill_q    <= 1'b0;
               end
            end
            REQ: begin
               if (bus.l2_req_ready_i && bus.kill_i) kill_q <= 1'b1;
            end
            FILL: begin
               if (bus.kill_i) kill_q <= 1'b1;
               if (bus.l2_rsp_valid_i) begin
                  line_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] <= bus.l2_rsp_data_i;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.miss_ready_o   = miss_ready;
   assign bus.l2_req_valid_o = l2_req_valid;
   assign bus.l2_req_idx_o   = idx_q;
   assign bus.mem_req_o      = writing ? victim_q : '0;
   assign bus.mem_we_o       = writing;
   assign bus.mem_addr_o     = idx_q;
   assign bus.mem_data_o     = line_q;
   assign bus.done_o         = writing;
   assign bus.done_way_o     = writing ? victim_q : '0;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed, table-driven bench for the instruction-cache refill controller.
module tb_sargantana_icache_refill;

   typedef struct {
      logic [5:0]        idx;
      logic [3:0]        way_valid;
      logic [3:0][63:0]  beats;
      logic [3:0]        exp_req;
   } vec_t;

   logic clk;
   logic rstn;
   int   testsRun    = 0;
   int   testsFailed = 0;
   vec_t vecs [7];

   sargantana_icache_refill_if bus ();

   sargantana_icache_refill dut (
      .clk_i (clk),
      .rstn_i(rstn),
      .bus   (bus)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      bus.miss_valid_i   = 1'b0;
      bus.miss_idx_i     = '0;
      bus.way_valid_i    = '0;
      bus.kill_i         = 1'b0;
      bus.l2_req_ready_i = 1'b0;
      bus.l2_rsp_valid_i = 1'b0;
      bus.l2_rsp_data_i  = '0;
   endtask

   // Present a miss for one cycle; the request must be up the next cycle.
   task automatic applyStimulus(input logic [5:0] idx, input logic [3:0] wv);
      bus.miss_valid_i = 1'b1;
      bus.miss_idx_i   = idx;
      bus.way_valid_i  = wv;
      tick();
      bus.miss_valid_i = 1'b0;
      bus.way_valid_i  = '0;
      checkOutput("req_valid_after_miss", bus.l2_req_valid_o, 1'b1);
      checkOutput("req_idx", bus.l2_req_idx_o, idx);
   endtask

   task automatic handshake();
      bus.l2_req_ready_i = 1'b1;
      tick();
      bus.l2_req_ready_i = 1'b0;
   endtask

   task automatic sendBeat(input logic [63:0] data);
      bus.l2_rsp_valid_i = 1'b1;
      bus.l2_rsp_data_i  = data;
      tick();
      bus.l2_rsp_valid_i = 1'b0;
      bus.l2_rsp_data_i  = '0;
   endtask

   // Check the single write cycle, then the return to idle.
   task automatic checkWrite(input string name, input logic [5:0] idx,
                             input logic [3:0][63:0] beats, input logic [3:0] exp_req);
      checkOutput({name, "_we"}, bus.mem_we_o, 1'b1);
      checkOutput({name, "_done"}, bus.done_o, 1'b1);
      checkOutput({name, "_mem_req"}, bus.mem_req_o, exp_req);
      checkOutput({name, "_done_way"}, bus.done_way_o, exp_req);
      checkOutput({name, "_addr"}, bus.mem_addr_o, idx);
      checkOutput({name, "_data"}, bus.mem_data_o, beats);
      checkOutput({name, "_ready_during_write"}, bus.miss_ready_o, 1'b0);
      tick();
      checkOutput({name, "_ready_after"}, bus.miss_ready_o, 1'b1);
      checkOutput({name, "_we_after"}, bus.mem_we_o, 1'b0);
      checkOutput({name, "_done_after"}, bus.done_o, 1'b0);
   endtask

   task automatic doRefill(input string name, input logic [5:0] idx, input logic [3:0] wv,
                           input logic [3:0][63:0] beats, input logic [3:0] exp_req);
      applyStimulus(idx, wv);
      handshake();
      for (int k = 0; k < 4; k++) sendBeat(beats[k]);
      checkWrite(name, idx, beats, exp_req);
   endtask

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Main sequence.
   initial begin
      logic [3:0][63:0] b;
      int validPattern [7];

      vecs[0] = '{6'h15, 4'b1011, '{64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111}, 4'b0100};
      vecs[1] = '{6'h01, 4'b1111, '{default: '0}, 4'b0001};
      vecs[2] = '{6'h02, 4'b1111, '{default: '0}, 4'b0010};
      vecs[3] = '{6'h03, 4'b0110, '{default: '0}, 4'b0001};
      vecs[4] = '{6'h04, 4'b1111, '{default: '0}, 4'b0100};
      vecs[5] = '{6'h05, 4'b1111, '{default: '0}, 4'b1000};
      vecs[6] = '{6'h06, 4'b1111, '{default: '0}, 4'b0001};
      for (int i = 1; i < 7; i++) begin
         for (int k = 0; k < 4; k++) vecs[i].beats[k] = {8{8'(i * 16 + k)}};
      end

      idleInputs();
      rstn = 1'b0;
      #12;
      checkOutput("rst_miss_ready", bus.miss_ready_o, 1'b1);
      checkOutput("rst_req_valid", bus.l2_req_valid_o, 1'b0);
      checkOutput("rst_mem_we", bus.mem_we_o, 1'b0);
      checkOutput("rst_mem_req", bus.mem_req_o, 4'b0000);
      checkOutput("rst_done", bus.done_o, 1'b0);
      checkOutput("rst_done_way", bus.done_way_o, 4'b0000);
      checkOutput("rst_mem_data", bus.mem_data_o, 256'h0);
      checkOutput("rst_mem_addr", bus.mem_addr_o, 6'h0);
      rstn = 1'b1;
      tick();

      // Basic line fill and round-robin rotation, with one invalid-way miss interleaved.
      for (int i = 0; i < 7; i++) begin
         doRefill($sformatf("vec%0d", i), vecs[i].idx, vecs[i].way_valid,
                  vecs[i].beats, vecs[i].exp_req);
      end

      // L2 holds off the request for five cycles; pointer is at way 1, invalid way wins.
      applyStimulus(6'h2A, 4'b0000);
      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput("stall_req_valid", bus.l2_req_valid_o, 1'b1);
         checkOutput("stall_req_idx", bus.l2_req_idx_o, 6'h2A);
      end
      handshake();
      checkOutput("stall_fill_req_valid", bus.l2_req_valid_o, 1'b0);
      for (int k = 0; k < 4; k++) b[k] = {16{4'(k + 5)}};
      for (int k = 0; k < 4; k++) sendBeat(b[k]);
      checkWrite("stall", 6'h2A, b, 4'b0001);

      // Beats arriving with gaps.
      validPattern = '{1, 0, 0, 1, 1, 0, 1};
      for (int k = 0; k < 4; k++) b[k] = {4{16'hB000 + 16'(k)}};
      applyStimulus(6'h33, 4'b1101);
      handshake();
      begin
         int beat = 0;
         for (int c = 0; c < 7; c++) begin
            if (validPattern[c] != 0) begin
               sendBeat(b[beat]);
               beat++;
            end else begin
               tick();
            end
            if (c < 6) checkOutput("gap_no_write", bus.mem_we_o, 1'b0);
         end
      end
      checkWrite("gap", 6'h33, b, 4'b0010);

      // Kill after beat 1: the rest is drained and nothing is written.
      applyStimulus(6'h10, 4'b1111);
      handshake();
      sendBeat(64'hDEAD0000);
      sendBeat(64'hDEAD0001);
      bus.kill_i = 1'b1;
      tick();
      bus.kill_i = 1'b0;
      sendBeat(64'hDEAD0002);
      checkOutput("kill_fill_busy", bus.miss_ready_o, 1'b0);
      sendBeat(64'hDEAD0003);
      checkOutput("kill_fill_we", bus.mem_we_o, 1'b0);
      checkOutput("kill_fill_done", bus.done_o, 1'b0);
      checkOutput("kill_fill_ready", bus.miss_ready_o, 1'b1);

      // Kill while the request is still waiting for L2.
      applyStimulus(6'h11, 4'b1111);
      bus.kill_i = 1'b1;
      tick();
      bus.kill_i = 1'b0;
      checkOutput("kill_req_valid", bus.l2_req_valid_o, 1'b0);
      checkOutput("kill_req_ready", bus.miss_ready_o, 1'b1);

      // Killed refills left the pointer at way 1.
      for (int k = 0; k < 4; k++) b[k] = {8{8'hC0 + 8'(k)}};
      doRefill("after_kill", 6'h12, 4'b1111, b, 4'b0010);

      // Asynchronous reset in the middle of FILL.
      applyStimulus(6'h3C, 4'b1111);
      handshake();
      sendBeat(64'hFACE);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("midrst_miss_ready", bus.miss_ready_o, 1'b1);
      checkOutput("midrst_req_valid", bus.l2_req_valid_o, 1'b0);
      checkOutput("midrst_mem_we", bus.mem_we_o, 1'b0);
      checkOutput("midrst_mem_data", bus.mem_data_o, 256'h0);
      checkOutput("midrst_mem_addr", bus.mem_addr_o, 6'h0);
      tick();
      rstn = 1'b1;
      sendBeat(64'hBAD0BAD0);
      checkOutput("late_beat_ignored", bus.mem_data_o, 256'h0);
      checkOutput("late_beat_ready", bus.miss_ready_o, 1'b1);
      for (int k = 0; k < 4; k++) b[k] = {8{8'hE0 + 8'(k)}};
      doRefill("after_reset", 6'h3D, 4'b1111, b, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
